// File: rtl/rob_pkg.sv
// Shared reorder-buffer definitions: sizing constants, the {wrap, idx} pointer type
// and pointer arithmetic.
package rob_pkg;

    localparam int ROB_DEPTH = 64;
    localparam int ROB_IDX_W = $clog2(ROB_DEPTH);

    typedef struct packed {
        logic                 wrap;
        logic [ROB_IDX_W-1:0] idx;
    } rob_ptr_t;

    // Adds n to a pointer whose live width is idx_w+1 bits. Bits above the live wrap bit
    // are cleared, so instances with DEPTH <= ROB_DEPTH can share this type. The carry
    // out of the index field toggles the wrap bit.
    function automatic rob_ptr_t rob_ptr_add(input rob_ptr_t ptr, input logic [1:0] n,
                                             input int idx_w);
        logic [ROB_IDX_W:0] sum;
        logic [ROB_IDX_W:0] mask;
        sum  = ptr + {{(ROB_IDX_W-1){1'b0}}, n};
        mask = {(ROB_IDX_W+1){1'b1}} >> (ROB_IDX_W - idx_w);
        return rob_ptr_t'(sum & mask);
    endfunction

endpackage

// File: rtl/rob_idx_dec.sv
// Index-to-one-hot decoder with enable, used to build the per-entry strobe vectors.
module rob_idx_dec #(
    parameter int DEPTH = 64,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             en,
    input  logic [IDX_W-1:0] idx,
    output logic [DEPTH-1:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en) onehot[idx] = 1'b1;
    end

endmodule

// File: rtl/rob_ctrl.sv
// Reorder-buffer head/tail controller. Allocates and retires up to two entries per
// cycle, tracks occupancy, and applies flush.
module rob_ctrl
    import rob_pkg::*;
#(
    parameter int DEPTH = ROB_DEPTH,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [1:0]       enq_req,
    output logic             enq_ready,
    output logic [IDX_W-1:0] enq_idx0,
    output logic [IDX_W-1:0] enq_idx1,
    output logic [DEPTH-1:0] entry_enq,
    input  logic [DEPTH-1:0] entry_deq,
    input  logic             commit_stall,
    output logic [DEPTH-1:0] commit,
    output logic [1:0]       commit_valid,
    output logic [IDX_W-1:0] commit_idx0,
    output logic [IDX_W-1:0] commit_idx1,
    input  logic             flush,
    output logic [IDX_W:0]   head_ptr,
    output logic [IDX_W:0]   tail_ptr,
    output logic [IDX_W:0]   count,
    output logic             empty,
    output logic             full
);

    localparam logic [IDX_W:0] CNT_DEPTH = (IDX_W+1)'(DEPTH);
    localparam logic [IDX_W:0] CNT_MAX2  = (IDX_W+1)'(DEPTH - 2);
    localparam logic [IDX_W:0] CNT_ONE   = (IDX_W+1)'(1);

    // The package pointer type is sized for ROB_DEPTH. This local DEPTH must not exceed it.
    function automatic logic [IDX_W:0] ptr_add(input logic [IDX_W:0] p, input logic [1:0] n);
        rob_ptr_t w;
        w          = '0;
        w[IDX_W:0] = p;
        w          = rob_ptr_add(w, n, IDX_W);
        return w[IDX_W:0];
    endfunction

    logic [1:0]       enq_fire;
    logic [1:0]       n_enq;
    logic [1:0]       n_cmt;
    logic [DEPTH-1:0] enq_oh0, enq_oh1, cmt_oh0, cmt_oh1;

    assign enq_ready = (count <= CNT_MAX2) & ~flush;
    assign enq_idx0  = tail_ptr[IDX_W-1:0];
    assign enq_idx1  = enq_idx0 + IDX_W'(1);

    // enq_req == 2'b10 is illegal, so slot 1 only fires alongside slot 0.
    assign enq_fire[0] = enq_ready & enq_req[0];
    assign enq_fire[1] = enq_ready & enq_req[0] & enq_req[1];

    assign commit_idx0     = head_ptr[IDX_W-1:0];
    assign commit_idx1     = commit_idx0 + IDX_W'(1);
    assign commit_valid[0] = ~flush & ~commit_stall & (count != '0) & entry_deq[commit_idx0];
    assign commit_valid[1] = commit_valid[0] & (count > CNT_ONE) & entry_deq[commit_idx1];

    assign n_enq = 2'(enq_fire[0]) + 2'(enq_fire[1]);
    assign n_cmt = 2'(commit_valid[0]) + 2'(commit_valid[1]);

    rob_idx_dec #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_enq_dec0 (
        .en(enq_fire[0]), .idx(enq_idx0), .onehot(enq_oh0));
    rob_idx_dec #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_enq_dec1 (
        .en(enq_fire[1]), .idx(enq_idx1), .onehot(enq_oh1));
    rob_idx_dec #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_cmt_dec0 (
        .en(commit_valid[0]), .idx(commit_idx0), .onehot(cmt_oh0));
    rob_idx_dec #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_cmt_dec1 (
        .en(commit_valid[1]), .idx(commit_idx1), .onehot(cmt_oh1));

    assign entry_enq = enq_oh0 | enq_oh1;
    assign commit    = cmt_oh0 | cmt_oh1;
    assign empty     = (count == '0);
    assign full      = (count == CNT_DEPTH);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else if (flush) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            head_ptr <= ptr_add(head_ptr, n_cmt);
            tail_ptr <= ptr_add(tail_ptr, n_enq);
            count    <= count + (IDX_W+1)'(n_enq) - (IDX_W+1)'(n_cmt);
        end
    end

endmodule

// File: tb/tb_rob_ctrl.sv
// Scoreboard bench for rob_ctrl at DEPTH=8. The reference model tracks the ROB as a queue
// of allocated entry indices plus running allocation/retire totals.
module tb_rob_ctrl;

    localparam int D = 8;
    localparam int W = 3;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [1:0]   enq_req = '0;
    logic         enq_ready;
    logic [W-1:0] enq_idx0, enq_idx1;
    logic [D-1:0] entry_enq;
    logic [D-1:0] entry_deq = '0;
    logic         commit_stall = 1'b0;
    logic [D-1:0] commit;
    logic [1:0]   commit_valid;
    logic [W-1:0] commit_idx0, commit_idx1;
    logic         flush = 1'b0;
    logic [W:0]   head_ptr, tail_ptr, count;
    logic         empty, full;

    rob_ctrl #(.DEPTH(D), .IDX_W(W)) dut (
        .clock(clock), .reset(reset), .enq_req(enq_req), .enq_ready(enq_ready),
        .enq_idx0(enq_idx0), .enq_idx1(enq_idx1), .entry_enq(entry_enq),
        .entry_deq(entry_deq), .commit_stall(commit_stall), .commit(commit),
        .commit_valid(commit_valid), .commit_idx0(commit_idx0), .commit_idx1(commit_idx1),
        .flush(flush), .head_ptr(head_ptr), .tail_ptr(tail_ptr), .count(count),
        .empty(empty), .full(full));

    always #5 clock = ~clock;

    typedef struct {
        logic         rdy;
        logic [W-1:0] i0, i1, c0, c1;
        logic [D-1:0] eenq, cmt;
        logic [1:0]   cv;
        logic [W:0]   hp, tp, cnt;
        logic         emp, ful;
    } exp_t;

    exp_t exp_q[$];
    int   rob_q[$];
    int   alloc_total = 0;
    int   cmt_total   = 0;
    int   checks      = 0;
    int   errors      = 0;

    always @(posedge clock)
        if (!reset) assert (enq_req != 2'b10) else $error("illegal enq_req 10 driven");

    task automatic chk(input string name, input int unsigned act, input int unsigned expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic exp_t reset_exp();
        exp_t e;
        e.rdy = 1'b1; e.i0 = '0; e.i1 = 3'd1; e.c0 = '0; e.c1 = 3'd1;
        e.eenq = '0; e.cmt = '0; e.cv = '0; e.hp = '0; e.tp = '0; e.cnt = '0;
        e.emp = 1'b1; e.ful = 1'b0;
        return e;
    endfunction

    // Drive one cycle of stimulus, record what the DUT must show, then advance the model.
    task automatic step(input logic [1:0] req, input logic [D-1:0] deq, input logic stall,
                        input logic fl);
        exp_t e;
        int   sz, nenq, ncmt;
        @(posedge clock); #1;
        enq_req = req; entry_deq = deq; commit_stall = stall; flush = fl;
        sz    = rob_q.size();
        e.hp  = 4'(cmt_total % 16);
        e.tp  = 4'(alloc_total % 16);
        e.cnt = 4'(sz);
        e.emp = (sz == 0);
        e.ful = (sz == D);
        e.rdy = (sz <= D - 2) && !fl;
        e.i0  = 3'(alloc_total % D);
        e.i1  = 3'((alloc_total + 1) % D);
        e.c0  = 3'(cmt_total % D);
        e.c1  = 3'((cmt_total + 1) % D);
        nenq  = !e.rdy ? 0 : (req == 2'b11) ? 2 : (req == 2'b01) ? 1 : 0;
        e.eenq = '0;
        for (int k = 0; k < nenq; k++) e.eenq[(alloc_total + k) % D] = 1'b1;
        ncmt = 0;
        if (!fl && !stall && sz >= 1 && deq[rob_q[0]]) begin
            ncmt = 1;
            if (sz >= 2 && deq[rob_q[1]]) ncmt = 2;
        end
        e.cmt = '0;
        for (int k = 0; k < ncmt; k++) e.cmt[rob_q[k]] = 1'b1;
        e.cv = (ncmt == 2) ? 2'b11 : (ncmt == 1) ? 2'b01 : 2'b00;
        exp_q.push_back(e);
        if (fl) begin
            rob_q.delete(); alloc_total = 0; cmt_total = 0;
        end else begin
            for (int k = 0; k < ncmt; k++) void'(rob_q.pop_front());
            for (int k = 0; k < nenq; k++) rob_q.push_back((alloc_total + k) % D);
            alloc_total += nenq;
            cmt_total   += ncmt;
        end
    endtask

    // Reset asserted between edges; the following negedge sample must already be clear.
    task automatic mid_reset();
        @(posedge clock); #1;
        enq_req = '0; entry_deq = '0; commit_stall = 1'b0; flush = 1'b0;
        reset = 1'b1;
        exp_q.push_back(reset_exp());
        rob_q.delete(); alloc_total = 0; cmt_total = 0;
        @(posedge clock); #1;
        reset = 1'b0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clock);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("enq_ready",    32'(enq_ready),    32'(e.rdy));
                chk("enq_idx0",     32'(enq_idx0),     32'(e.i0));
                chk("enq_idx1",     32'(enq_idx1),     32'(e.i1));
                chk("entry_enq",    32'(entry_enq),    32'(e.eenq));
                chk("commit_valid", 32'(commit_valid), 32'(e.cv));
                chk("commit",       32'(commit),       32'(e.cmt));
                chk("head_ptr",     32'(head_ptr),     32'(e.hp));
                chk("tail_ptr",     32'(tail_ptr),     32'(e.tp));
                chk("count",        32'(count),        32'(e.cnt));
                chk("empty",        32'(empty),        32'(e.emp));
                chk("full",         32'(full),         32'(e.ful));
                chk("ptr_invariant", 32'(count), 32'(4'(tail_ptr - head_ptr)));
                if (e.cv[0]) chk("commit_idx0", 32'(commit_idx0), 32'(e.c0));
                if (e.cv[1]) chk("commit_idx1", 32'(commit_idx1), 32'(e.c1));
            end
        end
    end

    initial begin : driver
        logic [1:0] r;
        int         pick;
        mid_reset();
        // Fill to full with paired allocations, then try once more while full.
        repeat (5) step(2'b11, '0, 1'b0, 1'b0);
        mid_reset();
        // Fill 4, retire the first two together.
        repeat (2) step(2'b11, '0, 1'b0, 1'b0);
        step(2'b00, 8'b0000_0011, 1'b0, 1'b0);
        step(2'b00, '0, 1'b0, 1'b0);
        // Head+1 complete but head not: in-order block, then release.
        step(2'b00, 8'b0000_1000, 1'b0, 1'b0);
        step(2'b00, 8'b0000_1100, 1'b0, 1'b0);
        // Stall blocks a committable head.
        step(2'b01, 8'b1111_1111, 1'b1, 1'b0);
        mid_reset();
        // Walk head to 6, place tail at 6+4, then enqueue and retire across the wrap.
        repeat (3) step(2'b11, '0, 1'b0, 1'b0);
        repeat (3) step(2'b00, 8'hFF, 1'b0, 1'b0);
        repeat (2) step(2'b11, '0, 1'b0, 1'b0);
        step(2'b11, 8'b1100_0000, 1'b0, 1'b0);
        step(2'b00, '0, 1'b0, 1'b0);
        // Flush with a pending allocation and a committable head.
        step(2'b11, 8'hFF, 1'b0, 1'b1);
        step(2'b00, '0, 1'b0, 1'b0);
        // Reset mid-burst with five entries live, then resume allocating.
        step(2'b11, '0, 1'b0, 1'b0);
        step(2'b11, '0, 1'b0, 1'b0);
        step(2'b01, '0, 1'b0, 1'b0);
        step(2'b00, '0, 1'b0, 1'b0);
        mid_reset();
        step(2'b11, '0, 1'b0, 1'b0);
        step(2'b00, '0, 1'b0, 1'b0);
        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            pick = int'($urandom_range(0, 2));
            r    = (pick == 0) ? 2'b00 : (pick == 1) ? 2'b01 : 2'b11;
            step(r, 8'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 39) == 0));
        end
        step(2'b00, '0, 1'b0, 1'b0);
        repeat (2) @(posedge clock);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
